cpu_bus_arbiter: RTL and testbench

Two-port bus arbiter that shares the single CPU system bus between the instruction fetch path (port A) and the data path (port B, the data-cache / memory-stage bus master).
Grants one requester at a time and holds the grant until that transaction completes, then releases the bus for one cycle.
Includes a watchdog that force-completes a hung transaction and flags the fault.
Sits between the CPU pipeline masters and the external bus / write buffer.

---
 rtl/cpu_bus_pkg.sv | 31 +++
 rtl/cpu_bus_watchdog.sv | 26 ++
 rtl/cpu_bus_arbiter.sv | 111 +++++++++++
 tb/tb_cpu_bus_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, grant owner and port bundle.
package cpu_bus_pkg;

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, RELEASE} state_t;

  typedef enum logic {GRANT_PORT_A, GRANT_PORT_B} grant_t;

  typedef struct packed {
    logic        rw;
    logic        request;
    logic [31:0] address;
    logic [31:0] wdata;
  } bus_request_t;

  // Winner for a new grant. On contention, fixed mode favours B and
  // round-robin mode hands the bus to whoever did not have it last.
  function automatic grant_t pick_grant(input logic req_a, input logic req_b,
                                        input grant_t last, input logic fixed);
    grant_t win;
    if (req_a && req_b) begin
      if (fixed) win = GRANT_PORT_B;
      else       win = (last == GRANT_PORT_B) ? GRANT_PORT_A : GRANT_PORT_B;
    end else if (req_b) begin
      win = GRANT_PORT_B;
    end else begin
      win = GRANT_PORT_A;
    end
    return win;
  endfunction

endpackage

// File: rtl/cpu_bus_watchdog.sv
// Transaction watchdog: counts granted cycles without bus ready and flags
// expiry in the cycle where the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
module cpu_bus_watchdog #(
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 11
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TIMEOUT_W-1:0] count;

  // Wait-cycle counter; held at zero outside a grant so each grant starts fresh.
  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear) count <= '0;
    else if (i_enable)       count <= count + 1'b1;
  end

  assign o_expired = (TIMEOUT != 0) && i_enable && (count == LAST);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Two-port CPU bus arbiter: instruction fetch (A) and data path (B) share one
// bus. Grant is held until ready or watchdog expiry, then one RELEASE cycle.
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int TIMEOUT        = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_rw,
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  input  logic [31:0] i_pa_wdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  output logic        o_pb_ready,
  input  logic [31:0] i_pb_address,
  output logic [31:0] o_pb_rdata,
  input  logic [31:0] i_pb_wdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic        o_timeout
);

  state_t       state, state_nxt;
  grant_t       last_grant, last_grant_nxt;
  grant_t       winner;
  logic         granted;
  logic         wd_expired;
  logic         done;
  logic         timeout_q;
  bus_request_t port_a, port_b, bus_sel;

  assign port_a  = '{rw: i_pa_rw, request: i_pa_request, address: i_pa_address, wdata: i_pa_wdata};
  assign port_b  = '{rw: i_pb_rw, request: i_pb_request, address: i_pb_address, wdata: i_pb_wdata};
  assign granted = (state == GRANT_A) || (state == GRANT_B);
  assign done    = granted && (i_bus_ready || wd_expired);
  assign winner  = pick_grant(i_pa_request, i_pb_request, last_grant, FIXED_PRIORITY);

  cpu_bus_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (!granted),
    .i_enable  (granted && !i_bus_ready),
    .o_expired (wd_expired)
  );

  // State, last-grant history and sticky fault flag.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state      <= IDLE;
      last_grant <= GRANT_PORT_B;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (wd_expired) timeout_q <= 1'b1;
    end
  end

  // Next-state: grant from IDLE, complete on ready/expiry, single RELEASE cycle.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (i_pa_request || i_pb_request) begin
          last_grant_nxt = winner;
          state_nxt      = (winner == GRANT_PORT_A) ? GRANT_A : GRANT_B;
        end
      end
      GRANT_A, GRANT_B: if (done) state_nxt = RELEASE;
      RELEASE:          state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Bus mux: granted port drives the bus, otherwise everything is zero.
  always_comb begin
    bus_sel = '0;
    case (state)
      GRANT_A: bus_sel = port_a;
      GRANT_B: bus_sel = port_b;
      default: bus_sel = '0;
    endcase
  end

  assign o_bus_rw      = bus_sel.rw;
  assign o_bus_request = bus_sel.request;
  assign o_bus_address = bus_sel.address;
  assign o_bus_wdata   = bus_sel.wdata;

  // A forced completion returns zero data; a real ready always wins over expiry.
  assign o_pa_ready = done && (state == GRANT_A);
  assign o_pb_ready = done && (state == GRANT_B);
  assign o_pa_rdata = wd_expired ? '0 : i_bus_rdata;
  assign o_pb_rdata = wd_expired ? '0 : i_bus_rdata;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter. Three instances share the stimulus:
// [0] round-robin TIMEOUT=16, [1] fixed priority TIMEOUT=16, [2] round-robin TIMEOUT=4.
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pa_rw, pa_req, pb_rw, pb_req, bus_ready;
  logic [31:0] pa_addr, pa_wdata, pb_addr, pb_wdata, bus_rdata;

  logic        pa_ready [3];
  logic        pb_ready [3];
  logic [31:0] pa_rdata [3];
  logic [31:0] pb_rdata [3];
  logic        bus_rw   [3];
  logic        bus_req  [3];
  logic [31:0] bus_addr [3];
  logic [31:0] bus_wdata[3];
  logic        tmo      [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_bus_arbiter #(
      .FIXED_PRIORITY (g == 1),
      .TIMEOUT        ((g == 2) ? 4 : 16),
      .TIMEOUT_W      (5)
    ) u_dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_pa_rw       (pa_rw),
      .i_pa_request  (pa_req),
      .o_pa_ready    (pa_ready[g]),
      .i_pa_address  (pa_addr),
      .o_pa_rdata    (pa_rdata[g]),
      .i_pa_wdata    (pa_wdata),
      .i_pb_rw       (pb_rw),
      .i_pb_request  (pb_req),
      .o_pb_ready    (pb_ready[g]),
      .i_pb_address  (pb_addr),
      .o_pb_rdata    (pb_rdata[g]),
      .i_pb_wdata    (pb_wdata),
      .o_bus_rw      (bus_rw[g]),
      .o_bus_request (bus_req[g]),
      .i_bus_ready   (bus_ready),
      .o_bus_address (bus_addr[g]),
      .i_bus_rdata   (bus_rdata),
      .o_bus_wdata   (bus_wdata[g]),
      .o_timeout     (tmo[g])
    );
  end

  // One reset edge with all inputs idle; returns at the negedge after it.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pa_rw = 0; pa_req = 0; pa_addr = 0; pa_wdata = 0;
    pb_rw = 0; pb_req = 0; pb_addr = 0; pb_wdata = 0;
    bus_ready = 0; bus_rdata = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus_req[0] !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req[0]); end
    checks++; if (bus_addr[0] !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr[0]); end
    checks++; if ({pa_ready[0], pb_ready[0], tmo[0]} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {pa_ready[0], pb_ready[0], tmo[0]}); end
  endtask

  task automatic test_a_read();
    do_reset();
    pa_req = 1; pa_addr = 32'h2000_0010;
    @(negedge clk); #1;  // 1st grant cycle
    checks++; if (bus_req[0] !== 1'b1 || bus_addr[0] !== 32'h2000_0010) begin errors++; $display("FAIL a_read_grant: req=%b addr=%h want 1 20000010", bus_req[0], bus_addr[0]); end
    checks++; if (pa_ready[0] !== 1'b0) begin errors++; $display("FAIL a_read_early_ready: got %b want 0", pa_ready[0]); end
    @(negedge clk);
    @(negedge clk); bus_ready = 1; bus_rdata = 32'hDEAD_BEEF; #1;  // 3rd grant cycle
    checks++; if (pa_ready[0] !== 1'b1 || pa_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL a_read_ready: rdy=%b data=%h want 1 deadbeef", pa_ready[0], pa_rdata[0]); end
    checks++; if (pb_ready[0] !== 1'b0) begin errors++; $display("FAIL a_read_pb_ready: got %b want 0", pb_ready[0]); end
    @(negedge clk); bus_ready = 0; #1;  // RELEASE, A still requesting
    checks++; if (bus_req[0] !== 1'b0 || pa_ready[0] !== 1'b0) begin errors++; $display("FAIL a_read_release: req=%b rdy=%b want 0 0", bus_req[0], pa_ready[0]); end
    @(negedge clk); #1;  // IDLE
    checks++; if (bus_req[0] !== 1'b0) begin errors++; $display("FAIL a_read_idle: got %b want 0", bus_req[0]); end
    @(negedge clk); #1;  // re-granted
    checks++; if (bus_req[0] !== 1'b1) begin errors++; $display("FAIL a_read_regrant: got %b want 1", bus_req[0]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    pa_req = 1; pa_addr = 32'hA0; pb_req = 1; pb_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus_ready = 1; bus_rdata = i; #1;
      checks++;
      if (pa_ready[0] !== (i % 2 == 0) || pb_ready[0] !== (i % 2 == 1) ||
          bus_addr[0] !== ((i % 2 == 0) ? 32'hA0 : 32'hB0)) begin
        errors++; $display("FAIL rr_txn%0d: pa=%b pb=%b addr=%h", i, pa_ready[0], pb_ready[0], bus_addr[0]);
      end
      checks++;
      if (pb_ready[1] !== 1'b1 || pa_ready[1] !== 1'b0) begin
        errors++; $display("FAIL fixed_txn%0d: pa=%b pb=%b want 0 1", i, pa_ready[1], pb_ready[1]);
      end
      @(negedge clk); bus_ready = 0;
      @(negedge clk);
    end
    pa_req = 0; pb_req = 0;
  endtask

  task automatic test_write_during_a();
    do_reset();
    pa_req = 1; pa_addr = 32'h300;
    @(negedge clk);
    pb_req = 1; pb_rw = 1; pb_addr = 32'h0000_0100; pb_wdata = 32'h1234_5678; #1;
    checks++; if (bus_addr[0] !== 32'h300 || bus_rw[0] !== 1'b0) begin errors++; $display("FAIL wr_a_hold1: addr=%h rw=%b want 300 0", bus_addr[0], bus_rw[0]); end
    @(negedge clk); #1;
    checks++; if (bus_addr[0] !== 32'h300) begin errors++; $display("FAIL wr_a_hold2: addr=%h want 300", bus_addr[0]); end
    @(negedge clk); bus_ready = 1; #1;
    checks++; if (pa_ready[0] !== 1'b1 || pb_ready[0] !== 1'b0 || bus_addr[0] !== 32'h300) begin errors++; $display("FAIL wr_a_done: pa=%b pb=%b addr=%h", pa_ready[0], pb_ready[0], bus_addr[0]); end
    @(negedge clk); bus_ready = 0; pa_req = 0; #1;
    checks++; if (bus_req[0] !== 1'b0) begin errors++; $display("FAIL wr_release: got %b want 0", bus_req[0]); end
    @(negedge clk); #1;
    checks++; if (bus_req[0] !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b want 0", bus_req[0]); end
    @(negedge clk); bus_ready = 1; #1;
    checks++;
    if (bus_req[0] !== 1'b1 || bus_rw[0] !== 1'b1 || bus_addr[0] !== 32'h100 || bus_wdata[0] !== 32'h1234_5678 || pb_ready[0] !== 1'b1) begin
      errors++; $display("FAIL wr_b_grant: req=%b rw=%b addr=%h wdata=%h rdy=%b", bus_req[0], bus_rw[0], bus_addr[0], bus_wdata[0], pb_ready[0]);
    end
    @(negedge clk); bus_ready = 0; pb_req = 0; pb_rw = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    pa_req = 1; pa_addr = 32'h40; bus_rdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      checks++; if (pa_ready[0] !== 1'b0 || tmo[0] !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d: rdy=%b tmo=%b want 0 0", k, pa_ready[0], tmo[0]); end
    end
    @(negedge clk); #1;  // 16th grant cycle
    checks++; if (pa_ready[0] !== 1'b1 || pa_rdata[0] !== 32'h0) begin errors++; $display("FAIL tmo_force: rdy=%b data=%h want 1 0", pa_ready[0], pa_rdata[0]); end
    @(negedge clk); pa_req = 0; pb_req = 1; pb_addr = 32'h80; #1;
    checks++; if (tmo[0] !== 1'b1 || bus_req[0] !== 1'b0) begin errors++; $display("FAIL tmo_flag: tmo=%b req=%b want 1 0", tmo[0], bus_req[0]); end
    checks++; if (tmo[2] !== 1'b1) begin errors++; $display("FAIL tmo4_flag: got %b want 1", tmo[2]); end
    @(negedge clk); #1;
    checks++; if (bus_req[0] !== 1'b0) begin errors++; $display("FAIL tmo_idle: got %b want 0", bus_req[0]); end
    @(negedge clk); bus_ready = 1; bus_rdata = 32'h0000_55AA; #1;
    checks++;
    if (pb_ready[0] !== 1'b1 || pb_rdata[0] !== 32'h55AA || bus_addr[0] !== 32'h80 || tmo[0] !== 1'b1) begin
      errors++; $display("FAIL tmo_b_txn: rdy=%b data=%h addr=%h tmo=%b", pb_ready[0], pb_rdata[0], bus_addr[0], tmo[0]);
    end
    @(negedge clk); bus_ready = 0; pb_req = 0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    pb_req = 1; pb_rw = 1; pb_addr = 32'h100; pb_wdata = 32'h1;
    @(negedge clk); #1;
    checks++; if (bus_req[0] !== 1'b1 || bus_rw[0] !== 1'b1) begin errors++; $display("FAIL rst_b_grant: req=%b rw=%b want 1 1", bus_req[0], bus_rw[0]); end
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; bus_ready = 1; pa_req = 1; pa_addr = 32'hA0; #1;
    checks++;
    if (bus_req[0] !== 1'b0 || pb_ready[0] !== 1'b0 || pa_ready[0] !== 1'b0 || tmo[0] !== 1'b0) begin
      errors++; $display("FAIL rst_abandon: req=%b pb=%b pa=%b tmo=%b want 0000", bus_req[0], pb_ready[0], pa_ready[0], tmo[0]);
    end
    @(negedge clk); #1;
    checks++; if (bus_addr[0] !== 32'hA0 || pa_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_first_a: addr=%h rdy=%b want a0 1", bus_addr[0], pa_ready[0]); end
    @(negedge clk); bus_ready = 0; pa_req = 0; pb_req = 0; pb_rw = 0;
  endtask

  task automatic test_ready_at_expiry();
    do_reset();
    pa_req = 1; pa_addr = 32'h44;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (pa_ready[2] !== 1'b0) begin errors++; $display("FAIL exp_early: got %b want 0", pa_ready[2]); end
    @(negedge clk); bus_ready = 1; bus_rdata = 32'hCAFE_F00D; #1;
    checks++; if (pa_ready[2] !== 1'b1 || pa_rdata[2] !== 32'hCAFE_F00D) begin errors++; $display("FAIL exp_coincide: rdy=%b data=%h want 1 cafef00d", pa_ready[2], pa_rdata[2]); end
    @(negedge clk); bus_ready = 0; pa_req = 0; #1;
    checks++; if (tmo[2] !== 1'b0) begin errors++; $display("FAIL exp_no_fault: got %b want 0", tmo[2]); end
  endtask

  initial begin
    rst_n = 1;
    pa_rw = 0; pa_req = 0; pa_addr = 0; pa_wdata = 0;
    pb_rw = 0; pb_req = 0; pb_addr = 0; pb_wdata = 0;
    bus_ready = 0; bus_rdata = 0;
    test_reset();
    test_a_read();
    test_round_robin();
    test_write_during_a();
    test_timeout();
    test_reset_mid_grant();
    test_ready_at_expiry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
